// File: rtl/lsu.sv
// RV32I load/store unit: one aligned data-bus transaction per memory instruction,
// with sign/zero-extended load writeback and fault reporting for bad accesses.
//
// state  | meaning
// S_IDLE | ready for a new access; faults are reported from here
// S_REQ  | bus request held until grant
// S_WAIT | load granted, waiting for read data
module lsu (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_ex_valid,
   output logic        o_ex_ready,
   input  logic        i_is_store,
   input  logic [2:0]  i_funct3,
   input  logic [31:0] i_addr,
   input  logic [31:0] i_wdata,
   input  logic [4:0]  i_rd,
   output logic        o_mem_req,
   input  logic        i_mem_gnt,
   output logic [31:0] o_mem_addr,
   output logic        o_mem_we,
   output logic [3:0]  o_mem_be,
   output logic [31:0] o_mem_wdata,
   input  logic        i_mem_rvalid,
   input  logic [31:0] i_mem_rdata,
   output logic        o_wb_valid,
   output logic [4:0]  o_wb_rd,
   output logic [31:0] o_wb_data,
   output logic        o_st_done,
   output logic        o_fault,
   output logic        o_fault_cause,
   output logic [31:0] o_fault_addr
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;

   logic [1:0]  r_off;
   logic [2:0]  r_f3;
   logic        r_store;
   logic [4:0]  r_rd;

   logic        w_accept;
   logic        w_illegal;
   logic        w_misal;
   logic [3:0]  w_be;
   logic [31:0] w_wdata_rep;
   logic [31:0] w_shift;
   logic [31:0] w_load;

   assign w_accept = i_ex_valid && (r_state == S_IDLE);

   assign w_illegal = (i_funct3 == 3'b011) || (i_funct3 == 3'b110) ||
                      (i_funct3 == 3'b111) || (i_is_store && i_funct3[2]);

   assign w_misal = ((i_funct3[1:0] == 2'b01) && i_addr[0]) ||
                    ((i_funct3[1:0] == 2'b10) && (i_addr[1:0] != 2'b00));

   // Lane mask and replicated store data depend only on access size and offset.
   always_comb begin
      w_be        = 4'b1111;
      w_wdata_rep = i_wdata;
      case (i_funct3[1:0])
         2'b00: begin
            w_be        = 4'b0001 << i_addr[1:0];
            w_wdata_rep = {4{i_wdata[7:0]}};
         end
         2'b01: begin
            w_be        = i_addr[1] ? 4'b1100 : 4'b0011;
            w_wdata_rep = {2{i_wdata[15:0]}};
         end
         default: begin
            w_be        = 4'b1111;
            w_wdata_rep = i_wdata;
         end
      endcase
   end

   assign w_shift = i_mem_rdata >> {r_off, 3'b000};

   always_comb begin
      w_load = w_shift;
      case (r_f3)
         3'b000:  w_load = {{24{w_shift[7]}}, w_shift[7:0]};
         3'b100:  w_load = {24'h000000, w_shift[7:0]};
         3'b001:  w_load = {{16{w_shift[15]}}, w_shift[15:0]};
         3'b101:  w_load = {16'h0000, w_shift[15:0]};
         default: w_load = w_shift;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) r_state <= S_IDLE;
      else         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      o_ex_ready  = 1'b0;
      o_mem_req   = 1'b0;
      case (r_state)
         S_IDLE: begin
            o_ex_ready = 1'b1;
            if (w_accept && !(w_illegal || w_misal)) w_state_nxt = S_REQ;
         end
         S_REQ: begin
            o_mem_req = 1'b1;
            if (i_mem_gnt) w_state_nxt = r_store ? S_IDLE : S_WAIT;
         end
         S_WAIT: begin
            if (i_mem_rvalid) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         o_mem_addr    <= '0;
         o_mem_we      <= 1'b0;
         o_mem_be      <= '0;
         o_mem_wdata   <= '0;
         o_wb_valid    <= 1'b0;
         o_wb_rd       <= '0;
         o_wb_data     <= '0;
         o_st_done     <= 1'b0;
         o_fault       <= 1'b0;
         o_fault_cause <= 1'b0;
         o_fault_addr  <= '0;
         r_off         <= '0;
         r_f3          <= '0;
         r_store       <= 1'b0;
         r_rd          <= '0;
      end else begin
         o_fault    <= 1'b0;
         o_st_done  <= 1'b0;
         o_wb_valid <= 1'b0;

         if (w_accept) begin
            if (w_illegal || w_misal) begin
               o_fault       <= 1'b1;
               o_fault_cause <= w_illegal;
               o_fault_addr  <= i_addr;
            end else begin
               o_mem_addr  <= {i_addr[31:2], 2'b00};
               o_mem_we    <= i_is_store;
               o_mem_be    <= w_be;
               o_mem_wdata <= w_wdata_rep;
               r_off       <= i_addr[1:0];
               r_f3        <= i_funct3;
               r_store     <= i_is_store;
               r_rd        <= i_rd;
            end
         end

         if ((r_state == S_REQ) && i_mem_gnt && r_store) o_st_done <= 1'b1;

         if ((r_state == S_WAIT) && i_mem_rvalid) begin
            o_wb_valid <= 1'b1;
            o_wb_rd    <= r_rd;
            o_wb_data  <= w_load;
         end
      end
   end

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: directed vector table, hand-written fault/reset sequences,
// and randomized accesses checked against a byte-addressed memory model.
module tb_lsu;

   logic        clk = 1'b0;
   logic        rst;
   logic        ex_valid;
   logic        ex_ready;
   logic        is_store;
   logic [2:0]  funct3;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [4:0]  rd;
   logic        mem_req;
   logic        mem_gnt;
   logic [31:0] mem_addr;
   logic        mem_we;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        st_done;
   logic        fault;
   logic        fault_cause;
   logic [31:0] fault_addr;

   always #5 clk = ~clk;

   lsu dut (
      .i_clk(clk), .i_reset(rst), .i_ex_valid(ex_valid), .o_ex_ready(ex_ready),
      .i_is_store(is_store), .i_funct3(funct3), .i_addr(addr), .i_wdata(wdata),
      .i_rd(rd), .o_mem_req(mem_req), .i_mem_gnt(mem_gnt), .o_mem_addr(mem_addr),
      .o_mem_we(mem_we), .o_mem_be(mem_be), .o_mem_wdata(mem_wdata),
      .i_mem_rvalid(mem_rvalid), .i_mem_rdata(mem_rdata), .o_wb_valid(wb_valid),
      .o_wb_rd(wb_rd), .o_wb_data(wb_data), .o_st_done(st_done), .o_fault(fault),
      .o_fault_cause(fault_cause), .o_fault_addr(fault_addr)
   );

   int n_vec = 0;
   int n_err = 0;

   logic [7:0] smem [256];
   logic [7:0] mmem [256];

   typedef struct {
      logic        st;
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] wd;
      logic [31:0] rdat;
      int          gdly;
      int          rdly;
      int          kind;
      logic [31:0] val;
      logic [3:0]  be;
      logic [31:0] mwd;
   } vec_t;

   vec_t tbl [16];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drives one access and plays the bus slave; returns what was observed.
   // kind: 0 load writeback, 1 store done, 2 fault, -1 nothing seen.
   task automatic run_access(
      input  logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
      input  logic [4:0] rdst, input int gdly, input int rdly, input logic use_mem,
      input  logic [31:0] rdat,
      output int kind, output logic [31:0] val, output logic [3:0] be,
      output logic [31:0] mwd, output logic [31:0] maddr, output logic mwe,
      output int lat, output int reqc, output logic hold_ok, output logic [4:0] wrd);
      int   gcyc;
      logic done;
      int   base;
      kind = -1; val = '0; be = '0; mwd = '0; maddr = '0; mwe = 1'b0;
      lat = 0; reqc = 0; hold_ok = 1'b1; wrd = '0; gcyc = -1; done = 1'b0;
      check("ready_before_accept", 32'(ex_ready), 32'd1);
      ex_valid = 1'b1; is_store = st; funct3 = f3; addr = a; wdata = wd; rd = rdst;
      tick();
      ex_valid = 1'b0;
      for (int c = 1; c < 200 && !done; c++) begin
         mem_gnt = 1'b0;
         mem_rvalid = 1'b0;
         if (fault || st_done || wb_valid) begin
            check("pulse_exclusive", 32'(fault) + 32'(st_done) + 32'(wb_valid), 32'd1);
            lat = c;
            done = 1'b1;
            if (fault) begin
               kind = 2; val = 32'(fault_cause); maddr = fault_addr;
            end else if (st_done) begin
               kind = 1;
            end else begin
               kind = 0; val = wb_data; wrd = wb_rd;
            end
         end else begin
            if (mem_req) begin
               if (ex_ready) hold_ok = 1'b0;
               if (reqc == 0) begin
                  be = mem_be; mwd = mem_wdata; maddr = mem_addr; mwe = mem_we;
               end else if (mem_be !== be || mem_wdata !== mwd || mem_addr !== maddr ||
                            mem_we !== mwe) begin
                  hold_ok = 1'b0;
               end
               reqc++;
               if (reqc > gdly) begin
                  mem_gnt = 1'b1;
                  gcyc = c;
                  if (use_mem && mem_we) begin
                     for (int l = 0; l < 4; l++)
                        if (mem_be[l]) smem[(int'(mem_addr[7:0]) + l) & 255] = mem_wdata[8*l +: 8];
                  end
               end
            end
            if (gcyc >= 0 && c == gcyc + 1 + rdly) begin
               mem_rvalid = 1'b1;
               if (use_mem) begin
                  base = int'(maddr[7:0]);
                  mem_rdata = {smem[(base+3)&255], smem[(base+2)&255],
                               smem[(base+1)&255], smem[base&255]};
               end else begin
                  mem_rdata = rdat;
               end
            end
            tick();
         end
      end
      mem_gnt = 1'b0;
      mem_rvalid = 1'b0;
      check("completed_in_budget", 32'(done), 32'd1);
      tick();
      check("pulses_one_cycle", {29'd0, fault, st_done, wb_valid}, 32'd0);
   endtask

   int          kind, lat, reqc, elat, sz, ek;
   logic [31:0] val, mwd, maddr, ev;
   logic [3:0]  be, ebe;
   logic        mwe, hold_ok;
   logic [4:0]  wrd;
   logic        seen;

   initial begin
      rst = 1'b1; ex_valid = 1'b0; is_store = 1'b0; funct3 = '0; addr = '0; wdata = '0;
      rd = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;

      tbl[0]  = '{1'b0, 3'b010, 32'h100,  32'h0,        32'hDEADBEEF, 0, 0, 0, 32'hDEADBEEF, 4'b1111, 32'h0};
      tbl[1]  = '{1'b0, 3'b000, 32'h203,  32'h0,        32'h80FF1234, 0, 0, 0, 32'hFFFFFF80, 4'b1000, 32'h0};
      tbl[2]  = '{1'b0, 3'b100, 32'h203,  32'h0,        32'h80FF1234, 0, 0, 0, 32'h00000080, 4'b1000, 32'h0};
      tbl[3]  = '{1'b0, 3'b101, 32'h202,  32'h0,        32'h80FF1234, 0, 0, 0, 32'h000080FF, 4'b1100, 32'h0};
      tbl[4]  = '{1'b0, 3'b001, 32'h202,  32'h0,        32'h80FF1234, 1, 2, 0, 32'hFFFF80FF, 4'b1100, 32'h0};
      tbl[5]  = '{1'b0, 3'b000, 32'h200,  32'h0,        32'h80FF1234, 2, 1, 0, 32'h00000034, 4'b0001, 32'h0};
      tbl[6]  = '{1'b1, 3'b000, 32'h301,  32'h000000AB, 32'h0,        3, 0, 1, 32'h0,        4'b0010, 32'hABABABAB};
      tbl[7]  = '{1'b1, 3'b001, 32'h302,  32'h1234CAFE, 32'h0,        0, 0, 1, 32'h0,        4'b1100, 32'hCAFECAFE};
      tbl[8]  = '{1'b1, 3'b010, 32'h304,  32'h89ABCDEF, 32'h0,        2, 0, 1, 32'h0,        4'b1111, 32'h89ABCDEF};
      tbl[9]  = '{1'b0, 3'b001, 32'h1001, 32'h0,        32'h0,        0, 0, 2, 32'h0,        4'b0000, 32'h0};
      tbl[10] = '{1'b0, 3'b011, 32'h40,   32'h0,        32'h0,        0, 0, 2, 32'h1,        4'b0000, 32'h0};
      tbl[11] = '{1'b1, 3'b100, 32'h44,   32'h0,        32'h0,        0, 0, 2, 32'h1,        4'b0000, 32'h0};
      tbl[12] = '{1'b0, 3'b010, 32'h102,  32'h0,        32'h0,        0, 0, 2, 32'h0,        4'b0000, 32'h0};
      tbl[13] = '{1'b0, 3'b110, 32'h101,  32'h0,        32'h0,        0, 0, 2, 32'h1,        4'b0000, 32'h0};
      tbl[14] = '{1'b1, 3'b001, 32'h303,  32'h0,        32'h0,        0, 0, 2, 32'h0,        4'b0000, 32'h0};
      tbl[15] = '{1'b0, 3'b101, 32'h201,  32'h0,        32'h0,        0, 0, 2, 32'h0,        4'b0000, 32'h0};

      repeat (3) tick();
      rst = 1'b0;
      check("reset_ctrl", {25'd0, mem_req, mem_we, wb_valid, st_done, fault, fault_cause, ex_ready},
            32'd1);
      check("reset_be", 32'(mem_be), 32'd0);
      check("reset_addr", mem_addr, 32'd0);
      check("reset_wdata", mem_wdata, 32'd0);
      check("reset_wb", wb_data | 32'(wb_rd), 32'd0);
      check("reset_faddr", fault_addr, 32'd0);
      tick();

      for (int i = 0; i < 16; i++) begin
         run_access(tbl[i].st, tbl[i].f3, tbl[i].a, tbl[i].wd, 5'(i + 1), tbl[i].gdly,
                    tbl[i].rdly, 1'b0, tbl[i].rdat,
                    kind, val, be, mwd, maddr, mwe, lat, reqc, hold_ok, wrd);
         elat = (tbl[i].kind == 0) ? 3 + tbl[i].gdly + tbl[i].rdly :
                (tbl[i].kind == 1) ? 2 + tbl[i].gdly : 1;
         check("tbl_kind", 32'(kind), 32'(tbl[i].kind));
         check("tbl_latency", 32'(lat), 32'(elat));
         if (tbl[i].kind == 2) begin
            check("tbl_fault_cause", val, tbl[i].val);
            check("tbl_fault_addr", maddr, tbl[i].a);
            check("tbl_fault_no_req", 32'(reqc), 32'd0);
         end else begin
            check("tbl_be", 32'(be), 32'(tbl[i].be));
            check("tbl_mem_addr", maddr, tbl[i].a & 32'hFFFF_FFFC);
            check("tbl_req_cycles", 32'(reqc), 32'(tbl[i].gdly + 1));
            check("tbl_hold", 32'(hold_ok), 32'd1);
            check("tbl_we", 32'(mwe), 32'(tbl[i].st));
            if (tbl[i].kind == 0) begin
               check("tbl_wb_data", val, tbl[i].val);
               check("tbl_wb_rd", 32'(wrd), 32'(i + 1));
            end else begin
               check("tbl_mem_wdata", mwd, tbl[i].mwd);
            end
         end
      end

      // Back-to-back faulting accepts.
      ex_valid = 1'b1; is_store = 1'b0; funct3 = 3'b001; addr = 32'h1001;
      tick();
      check("b2b_fault1", {28'd0, fault, fault_cause, mem_req, ex_ready}, 32'b1001);
      check("b2b_faddr1", fault_addr, 32'h1001);
      funct3 = 3'b011; addr = 32'h2000;
      tick();
      ex_valid = 1'b0;
      check("b2b_fault2", {28'd0, fault, fault_cause, mem_req, ex_ready}, 32'b1101);
      check("b2b_faddr2", fault_addr, 32'h2000);
      tick();
      check("b2b_fault_end", {29'd0, fault, mem_req, wb_valid}, 32'd0);

      // Reset while a load waits for data, then a stray rvalid.
      ex_valid = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h100; rd = 5'd7;
      tick();
      ex_valid = 1'b0;
      check("abort_req", 32'(mem_req), 32'd1);
      mem_gnt = 1'b1;
      tick();
      mem_gnt = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("abort_ctrl", {25'd0, mem_req, mem_we, wb_valid, st_done, fault, fault_cause, ex_ready},
            32'd1);
      check("abort_be", 32'(mem_be), 32'd0);
      check("abort_addr", mem_addr, 32'd0);
      check("abort_wdata", mem_wdata, 32'd0);
      check("abort_wb", wb_data | 32'(wb_rd), 32'd0);
      check("abort_faddr", fault_addr, 32'd0);
      mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
      tick();
      mem_rvalid = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 4; c++) begin
         if (wb_valid) seen = 1'b1;
         tick();
      end
      check("abort_no_wb", 32'(seen), 32'd0);
      run_access(1'b0, 3'b010, 32'h100, 32'h0, 5'd9, 0, 0, 1'b0, 32'hCAFEF00D,
                 kind, val, be, mwd, maddr, mwe, lat, reqc, hold_ok, wrd);
      check("post_abort_kind", 32'(kind), 32'd0);
      check("post_abort_data", val, 32'hCAFEF00D);
      check("post_abort_rd", 32'(wrd), 32'd9);
      check("post_abort_lat", 32'(lat), 32'd3);

      // Randomized accesses against a byte-array memory model.
      for (int k = 0; k < 256; k++) begin
         smem[k] = 8'($urandom);
         mmem[k] = smem[k];
      end
      for (int n = 0; n < 1000; n++) begin
         logic        st;
         logic [2:0]  f3;
         logic [31:0] a, wd;
         logic [4:0]  rdst;
         int          g, r, lane;
         logic        illegal, mis;
         st = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 7) == 0) f3 = 3'($urandom_range(0, 7));
         else if (st) f3 = 3'($urandom_range(0, 2));
         else begin
            case ($urandom_range(0, 4))
               0: f3 = 3'b000;
               1: f3 = 3'b001;
               2: f3 = 3'b010;
               3: f3 = 3'b100;
               default: f3 = 3'b101;
            endcase
         end
         sz = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
         a = 32'h0001_0000 | 32'($urandom_range(0, 255));
         if ($urandom_range(0, 3) != 0) a = a & ~32'(sz - 1);
         wd = $urandom;
         rdst = 5'($urandom);
         g = $urandom_range(0, 3);
         r = $urandom_range(0, 3);
         illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || (st && f3[2]);
         mis = (int'(a[1:0]) % sz) != 0;
         ek = (illegal || mis) ? 2 : (st ? 1 : 0);
         elat = (ek == 0) ? 3 + g + r : (ek == 1) ? 2 + g : 1;
         run_access(st, f3, a, wd, rdst, g, r, 1'b1, 32'h0,
                    kind, val, be, mwd, maddr, mwe, lat, reqc, hold_ok, wrd);
         check("rnd_kind", 32'(kind), 32'(ek));
         check("rnd_latency", 32'(lat), 32'(elat));
         if (ek == 2) begin
            check("rnd_fault_cause", val, 32'(illegal));
            check("rnd_fault_addr", maddr, a);
            check("rnd_fault_no_req", 32'(reqc), 32'd0);
         end else begin
            ebe = '0;
            for (int k = 0; k < sz; k++) ebe[int'(a[1:0]) + k] = 1'b1;
            check("rnd_be", 32'(be), 32'(ebe));
            check("rnd_mem_addr", maddr, {a[31:2], 2'b00});
            check("rnd_we", 32'(mwe), 32'(st));
            check("rnd_req_hold", 32'(hold_ok) + 32'(reqc), 32'(g + 2));
            if (st) begin
               for (int k = 0; k < sz; k++) begin
                  lane = int'(a[1:0]) + k;
                  check("rnd_store_lane", 32'(mwd[8*lane +: 8]), 32'(wd[8*k +: 8]));
                  mmem[(int'(a[7:0]) + k) & 255] = wd[8*k +: 8];
               end
            end else begin
               ev = '0;
               for (int k = 0; k < sz; k++)
                  ev = ev | (32'(mmem[(int'(a[7:0]) + k) & 255]) << (8*k));
               if (sz < 4 && !f3[2] && ev[8*sz-1]) ev = ev | (32'hFFFF_FFFF << (8*sz));
               check("rnd_wb_data", val, ev);
               check("rnd_wb_rd", 32'(wrd), 32'(rdst));
            end
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
